apb_slave_mem: RTL and testbench

//  APB3 completer (slave) with word-addressed register memory and programmable wait states.

---
 rtl/apb_slave_mem.sv | 188 ++++++++++++++++++
 tb/tb_apb_slave_mem.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_slave_mem
//
// APB3 completer backed by a word-addressed register memory, with a fixed,
// parameterised number of wait states on every transfer.
//
// Setup phase (PSEL=1, PENABLE=0) latches the address, direction, write data
// and, when enabled, the byte strobes. The access phase then holds PREADY
// low for WAIT_CYCLES cycles, raises it for exactly one cycle, and retires
// the transfer at the edge that samples PSEL && PENABLE && PREADY. Addresses
// at or above MEM_DEPTH complete with PSLVERR=1, never touch memory, and
// read back as zero.
//
// Optional feature macro:
//   APB_SLV_PSTRB_EN - adds the PSTRB port; writes update only the byte
//                      lanes whose strobe bit is set.
//
// Parameters:
//   ADDR_WIDTH  - PADDR width (word index, no byte offset)
//   DATA_WIDTH  - PWDATA/PRDATA width, multiple of 8
//   MEM_DEPTH   - number of words; PADDR >= MEM_DEPTH is out of range
//   WAIT_CYCLES - access cycles with PREADY low before completion
//
// Ports:
//   PCLK    in   clock, all logic on the rising edge
//   PRESET  in   synchronous active-high reset
//   PSEL    in   completer select
//   PENABLE in   access-phase qualifier
//   PWRITE  in   1 = write, 0 = read
//   PADDR   in   word address
//   PWDATA  in   write data
//   PSTRB   in   byte-lane write enables (APB_SLV_PSTRB_EN only)
//   PREADY  out  transfer completes in the cycle this is high
//   PRDATA  out  read data, valid while PREADY=1 on a read; held afterwards
//   PSLVERR out  error flag, valid while PREADY=1
// ---------------------------------------------------------------------------
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  localparam int STRB_W = DATA_WIDTH / 8;
  // A zero-wait build still needs a one-bit counter to keep widths legal.
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [CNT_W-1:0]    WAIT_LOAD   = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
`ifdef APB_SLV_PSTRB_EN
  logic [STRB_W-1:0]       strb_q;
`endif
  logic [CNT_W-1:0]        wait_cnt;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    setup_seen;
  logic                    complete;
  logic [ADDR_WIDTH-1:0]   resp_addr;
  logic                    resp_write;
  logic                    resp_err;
  logic [DATA_WIDTH-1:0]   read_word;
  logic                    latched_err;
  logic                    do_write;

  // The response is normally built from the latched address, but a
  // zero-wait build answers at the setup edge itself, before the latch
  // has taken the new address, so the live bus is used there instead.
  always_comb begin
    setup_seen  = (state == IDLE) && PSEL && !PENABLE;
    complete    = (state == ACCESS) && PSEL && PENABLE && PREADY;
    resp_addr   = setup_seen ? PADDR  : addr_q;
    resp_write  = setup_seen ? PWRITE : write_q;
    resp_err    = ({1'b0, resp_addr} >= DEPTH_LIMIT);
    read_word   = resp_err ? '0 : mem[resp_addr[IDX_W-1:0]];
    latched_err = ({1'b0, addr_q} >= DEPTH_LIMIT);
    do_write    = !PRESET && complete && write_q && !latched_err;
  end

  // Transfer FSM. PREADY, PSLVERR and PRDATA are all registered here so
  // the bus sees glitch-free outputs. The wait counter counts down the
  // remaining low-PREADY cycles; PREADY is raised at the edge where it
  // reaches zero and dropped again at the completion edge.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      PREADY   <= 1'b0;
      PRDATA   <= '0;
      PSLVERR  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup_seen) begin
            state    <= ACCESS;
            addr_q   <= PADDR;
            write_q  <= PWRITE;
            wdata_q  <= PWDATA;
`ifdef APB_SLV_PSTRB_EN
            strb_q   <= PSTRB;
`endif
            wait_cnt <= WAIT_LOAD;
            if (WAIT_CYCLES == 0) begin
              PREADY  <= 1'b1;
              PSLVERR <= resp_err;
              if (!resp_write) begin
                PRDATA <= read_word;
              end
            end
          end
        end

        ACCESS: begin
          if (!PSEL) begin
            // Master abandoned the transfer: no write, no response.
            state    <= IDLE;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            wait_cnt <= '0;
          end else if (PREADY) begin
            if (PENABLE) begin
              state   <= IDLE;
              PREADY  <= 1'b0;
              PSLVERR <= 1'b0;
            end
          end else if (wait_cnt > CNT_ONE) begin
            wait_cnt <= wait_cnt - CNT_ONE;
          end else begin
            wait_cnt <= '0;
            PREADY   <= 1'b1;
            PSLVERR  <= resp_err;
            if (!resp_write) begin
              PRDATA <= read_word;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory array has no reset. Writes land at the completion edge and are
  // suppressed for out-of-range addresses and when reset is asserted.
  always_ff @(posedge PCLK) begin
    if (do_write) begin
`ifdef APB_SLV_PSTRB_EN
      for (int i = 0; i < STRB_W; i++) begin
        if (strb_q[i]) begin
          mem[addr_q[IDX_W-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
`else
      mem[addr_q[IDX_W-1:0]] <= wdata_q;
`endif
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_apb_slave_mem
//
// Directed bench for apb_slave_mem with default parameters (WAIT_CYCLES=2,
// MEM_DEPTH=256). A table of single transfers covers in-range and
// out-of-range reads and writes, including the aliasing boundary addresses
// 0x100/0x1FF; hand-written sequences cover back-to-back transfers, an
// aborted write, reset mid-transfer, a stray PENABLE in IDLE and, when
// APB_SLV_PSTRB_EN is defined, byte-lane writes.
// ---------------------------------------------------------------------------
module tb_apb_slave_mem;

  localparam int WAIT_EXP  = 2;
  localparam int MAX_WAIT  = 20;
  localparam int NUM_VECS  = 12;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [8:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int checks;
  int failures;

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [NUM_VECS];

  apb_slave_mem dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB   (PSTRB),
`endif
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR)
  );

  // 10 ns clock
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Compare one observed value against the bench's own expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Park the bus for one cycle.
  task automatic idleCycle();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    @(posedge PCLK);
    #1;
  endtask

  // Run one full transfer starting now (called #1 after an edge). Counts the
  // access cycles with PREADY low, captures the response while PREADY is
  // high and confirms PREADY drops right after the completion edge. Leaves
  // the bus in its access-phase state so a caller may go straight into the
  // next setup phase.
  task automatic applyStimulus(input logic wr, input logic [8:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               output logic [31:0] rdata, output logic err,
                               output int waits);
    bit done;
    done    = 1'b0;
    waits   = 0;
    rdata   = '0;
    err     = 1'b0;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = data;
    PSTRB   = strb;
    @(posedge PCLK);
    #1;
    PENABLE = 1'b1;
    for (int k = 0; k < MAX_WAIT && !done; k++) begin
      if (PREADY === 1'b1) begin
        rdata = PRDATA;
        err   = PSLVERR;
        done  = 1'b1;
      end else begin
        waits++;
      end
      @(posedge PCLK);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL pready_timeout addr=0x%03h actual=0 expected=1", addr);
      PSEL    = 1'b0;
      PENABLE = 1'b0;
    end else begin
      checkOutput("pready_one_cycle", {31'b0, PREADY}, 32'h0);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          wt;

  initial begin
    checks   = 0;
    failures = 0;
    PRESET   = 1'b1;
    PSEL     = 1'b0;
    PENABLE  = 1'b0;
    PWRITE   = 1'b0;
    PADDR    = '0;
    PWDATA   = '0;
    PSTRB    = 4'hF;

    vecs[0]  = '{1'b1, 9'h010, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 9'h0FF, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 9'h1FF, 32'h12345678, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 9'h1FF, 32'h0,        32'h0,        1'b1};
    vecs[5]  = '{1'b0, 9'h0FF, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[6]  = '{1'b1, 9'h000, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 9'h100, 32'h0BADF00D, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 9'h000, 32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[9]  = '{1'b1, 9'h030, 32'h11111111, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 9'h040, 32'h44444444, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 9'h030, 32'h0,        32'h11111111, 1'b0};

    // Reset state
    repeat (2) @(posedge PCLK);
    #1;
    checkOutput("reset_pready",  {31'b0, PREADY},  32'h0);
    checkOutput("reset_prdata",  PRDATA,           32'h0);
    checkOutput("reset_pslverr", {31'b0, PSLVERR}, 32'h0);
    PRESET = 1'b0;
    idleCycle();

    // Table of single transfers, an idle cycle between each
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF, rd, er, wt);
      checkOutput($sformatf("vec%0d_waits", i), wt, WAIT_EXP);
      checkOutput($sformatf("vec%0d_pslverr", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      if (!vecs[i].wr) begin
        checkOutput($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rdata);
      end
      idleCycle();
    end

    // PRDATA holds the last read value after completion
    idleCycle();
    checkOutput("prdata_hold", PRDATA, 32'h11111111);

    // Back-to-back writes with no idle cycle between them
    applyStimulus(1'b1, 9'h020, 32'h0000AAAA, 4'hF, rd, er, wt);
    checkOutput("b2b_first_err", {31'b0, er}, 32'h0);
    applyStimulus(1'b1, 9'h021, 32'h55555555, 4'hF, rd, er, wt);
    checkOutput("b2b_second_waits", wt, WAIT_EXP);
    checkOutput("b2b_second_err", {31'b0, er}, 32'h0);
    idleCycle();
    applyStimulus(1'b0, 9'h020, 32'h0, 4'hF, rd, er, wt);
    checkOutput("b2b_read_020", rd, 32'h0000AAAA);
    applyStimulus(1'b0, 9'h021, 32'h0, 4'hF, rd, er, wt);
    checkOutput("b2b_read_021", rd, 32'h55555555);
    idleCycle();

    // Write aborted by PSEL dropping in the first access cycle
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 9'h030;
    PWDATA  = 32'hFFFFFFFF;
    @(posedge PCLK);
    #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge PCLK);
      #1;
      checkOutput($sformatf("abort_no_pready%0d", k), {31'b0, PREADY}, 32'h0);
    end
    applyStimulus(1'b0, 9'h030, 32'h0, 4'hF, rd, er, wt);
    checkOutput("abort_readback", rd, 32'h11111111);
    idleCycle();

`ifdef APB_SLV_PSTRB_EN
    // Byte-lane write: lanes 0 and 2 take the new data
    applyStimulus(1'b1, 9'h030, 32'hAABBCCDD, 4'b0101, rd, er, wt);
    idleCycle();
    applyStimulus(1'b0, 9'h030, 32'h0, 4'b0000, rd, er, wt);
    checkOutput("pstrb_readback", rd, 32'h11BB11DD);
    idleCycle();
`endif

    // Reset pulsed during the wait states of a write to 0x040
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 9'h040;
    PWDATA  = 32'h77777777;
    @(posedge PCLK);
    #1;
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    PRESET  = 1'b1;
    @(posedge PCLK);
    #1;
    checkOutput("midreset_pready",  {31'b0, PREADY},  32'h0);
    checkOutput("midreset_prdata",  PRDATA,           32'h0);
    checkOutput("midreset_pslverr", {31'b0, PSLVERR}, 32'h0);
    PRESET  = 1'b0;
    idleCycle();

    // IDLE must ignore PENABLE=1 without a preceding setup phase
    PSEL    = 1'b1;
    PENABLE = 1'b1;
    PWRITE  = 1'b0;
    PADDR   = 9'h010;
    for (int k = 0; k < 4; k++) begin
      @(posedge PCLK);
      #1;
      checkOutput($sformatf("stray_enable%0d", k), {31'b0, PREADY}, 32'h0);
    end
    idleCycle();

    applyStimulus(1'b0, 9'h010, 32'h0, 4'hF, rd, er, wt);
    checkOutput("post_reset_read_010", rd, 32'hDEADBEEF);
    checkOutput("post_reset_waits", wt, WAIT_EXP);
    applyStimulus(1'b0, 9'h040, 32'h0, 4'hF, rd, er, wt);
    checkOutput("dropped_write_040", rd, 32'h44444444);
    idleCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
